// File: rtl/fb_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fb_pipe_ctrl_pkg
//   Shared types and helpers for the Firebird pipeline sequencer.
//   - pctrl_state_e : sequencer states (2-bit encoding)
//   - pipe_ctrl_t   : bundle of PC / pipeline-register controls
//   - ctrl_frozen() : controls used while a data access is outstanding
//   - ctrl_run()    : RUN-mode priority (branch > load-use > fetch wait)
// ---------------------------------------------------------------------------
package fb_pipe_ctrl_pkg;

  localparam int FB_PCTRL_TO_W = 8;

  typedef enum logic [1:0] {
    FB_PCTRL_RUN  = 2'd0,
    FB_PCTRL_WAIT = 2'd1,
    FB_PCTRL_ERR  = 2'd2
  } pctrl_state_e;

  typedef struct packed {
    logic pc_we;
    logic pc_sel_branch;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pipe_ctrl_t;

  // Everything upstream of MEM/WB holds. MEM/WB keeps we=1 alongside its
  // flush so a register is never told "hold" and "bubble" at the same time;
  // the flush wins and no duplicate writeback reaches WB.
  function automatic pipe_ctrl_t ctrl_frozen();
    pipe_ctrl_t c;
    c             = '0;
    c.memwb_we    = 1'b1;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

  function automatic pipe_ctrl_t ctrl_run(input logic branch_taken,
                                          input logic load_use,
                                          input logic imem_ready);
    pipe_ctrl_t c;
    c          = '0;
    c.pc_we    = 1'b1;
    c.ifid_we  = 1'b1;
    c.idex_we  = 1'b1;
    c.exmem_we = 1'b1;
    c.memwb_we = 1'b1;
    if (branch_taken) begin
      // Redirect: squash the three younger instructions, let MEM retire.
      c.pc_sel_branch = 1'b1;
      c.ifid_flush    = 1'b1;
      c.idex_flush    = 1'b1;
      c.exmem_flush   = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, push a bubble into EX.
      c.pc_we      = 1'b0;
      c.ifid_we    = 1'b0;
      c.idex_flush = 1'b1;
    end else if (!imem_ready) begin
      // No instruction word: hold PC, feed a bubble into ID.
      c.pc_we      = 1'b0;
      c.ifid_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/fb_hazard_detect.sv
// ---------------------------------------------------------------------------
// fb_hazard_detect
//   Load-use detector: the load in EX writes a register that the instruction
//   in ID reads. x0 never creates a dependency.
//   Ports:
//     id_rs1, id_rs2         source indices of the ID instruction
//     id_use_rs1, id_use_rs2 ID instruction actually reads that source
//     ex_mem_read            EX instruction is a load
//     ex_register_rd         destination of the EX instruction
//     load_use               stall request (combinational)
// ---------------------------------------------------------------------------
module fb_hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_register_rd,
  output logic       load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = id_use_rs1 && (id_rs1 == ex_register_rd);
  assign hit_rs2  = id_use_rs2 && (id_rs2 == ex_register_rd);
  assign load_use = ex_mem_read && (ex_register_rd != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/fb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// fb_pipe_ctrl
//   Central pipeline sequencer for the 5-stage Firebird core. Drives PC and
//   pipeline-register write enables / flushes, resolves data-memory wait,
//   branch redirect, load-use and fetch-wait hazards, owns the data-memory
//   request, a wait-state timeout and stall/flush performance counters.
//
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     imem_ready             instruction word valid this cycle
//     id_*, ex_*             load-use hazard inputs
//     mem_mem_read/write     load / store sitting in MEM
//     mem_branch_taken       branch in MEM resolved taken
//     dmem_ready             data memory completes this cycle
//     dmem_req               data memory request
//     pc_we, pc_sel_branch   PC enable / branch-target select
//     *_we, *_flush          pipeline-register enable / bubble insert
//     dmem_err               sticky wait-state timeout
//     stall_cnt, flush_cnt   cycles with pc_we=0 / branch redirects
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   RUN   | normal flow; hazards resolved by priority
//   WAIT  | data access outstanding; pipeline frozen, timeout running
//   ERR   | access timed out; pipeline frozen, no request, exit via rst
// ---------------------------------------------------------------------------
module fb_pipe_ctrl
  import fb_pipe_ctrl_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 255,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_register_rd,
  input  logic             mem_mem_read,
  input  logic             mem_mem_write,
  input  logic             mem_branch_taken,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_we,
  output logic             pc_sel_branch,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [FB_PCTRL_TO_W-1:0] TO_LIMIT = FB_PCTRL_TO_W'(DMEM_TIMEOUT);

  pctrl_state_e             state;
  pctrl_state_e             state_nxt;
  logic [FB_PCTRL_TO_W-1:0] to_cnt;
  logic [FB_PCTRL_TO_W-1:0] to_cnt_nxt;
  pipe_ctrl_t               ctrl;
  logic                     req;
  logic                     mem_op;
  logic                     load_use;

  assign mem_op = mem_mem_read | mem_mem_write;

  fb_hazard_detect u_hazard (
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_mem_read    (ex_mem_read),
    .ex_register_rd (ex_register_rd),
    .load_use       (load_use)
  );

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    ctrl       = '0;
    req        = 1'b0;
    if (!rst) begin
      unique case (state)
        FB_PCTRL_RUN: begin
          if (mem_op && !dmem_ready) begin
            // The first cycle of a wait already freezes the pipeline.
            req        = 1'b1;
            ctrl       = ctrl_frozen();
            state_nxt  = FB_PCTRL_WAIT;
            to_cnt_nxt = '0;
          end else begin
            // Zero-wait accesses fall through to the normal priority chain;
            // a branch coincident with a memory op is only seen here once
            // the memory side is satisfied.
            req  = mem_op;
            ctrl = ctrl_run(mem_branch_taken, load_use, imem_ready);
          end
        end
        FB_PCTRL_WAIT: begin
          req = 1'b1;
          if (dmem_ready) begin
            ctrl       = ctrl_run(mem_branch_taken, load_use, imem_ready);
            state_nxt  = FB_PCTRL_RUN;
            to_cnt_nxt = '0;
          end else begin
            ctrl = ctrl_frozen();
            if (to_cnt == TO_LIMIT) begin
              state_nxt = FB_PCTRL_ERR;
            end else begin
              to_cnt_nxt = to_cnt + FB_PCTRL_TO_W'(1);
            end
          end
        end
        FB_PCTRL_ERR: begin
          ctrl = ctrl_frozen();
        end
        default: begin
          state_nxt = FB_PCTRL_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FB_PCTRL_RUN;
      to_cnt    <= '0;
      dmem_err  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;
      if (state_nxt == FB_PCTRL_ERR) begin
        dmem_err <= 1'b1;
      end
      if (!ctrl.pc_we) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (ctrl.pc_sel_branch) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign dmem_req      = req;
  assign pc_we         = ctrl.pc_we;
  assign pc_sel_branch = ctrl.pc_sel_branch;
  assign ifid_we       = ctrl.ifid_we;
  assign idex_we       = ctrl.idex_we;
  assign exmem_we      = ctrl.exmem_we;
  assign memwb_we      = ctrl.memwb_we;
  assign ifid_flush    = ctrl.ifid_flush;
  assign idex_flush    = ctrl.idex_flush;
  assign exmem_flush   = ctrl.exmem_flush;
  assign memwb_flush   = ctrl.memwb_flush;

endmodule

// File: tb/tb_fb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fb_pipe_ctrl
//   Directed scenarios followed by randomized traffic, all checked against a
//   behavioural model of the sequencer kept in this bench.
// ---------------------------------------------------------------------------
module tb_fb_pipe_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_ready;
  logic [4:0]       id_rs1, id_rs2, ex_register_rd;
  logic             id_use_rs1, id_use_rs2, ex_mem_read;
  logic             mem_mem_read, mem_mem_write, mem_branch_taken, dmem_ready;
  logic             dmem_req, pc_we, pc_sel_branch;
  logic             ifid_we, idex_we, exmem_we, memwb_we;
  logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic             dmem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model
  bit          m_waiting;
  bit          m_failed;
  int          m_wait_cycles;
  logic [31:0] m_stalls;
  logic [31:0] m_flushes;

  always #5 clk = ~clk;

  fb_pipe_ctrl #(.DMEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_ready(imem_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_mem_read(ex_mem_read), .ex_register_rd(ex_register_rd),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_branch_taken(mem_branch_taken), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_we(pc_we), .pc_sel_branch(pc_sel_branch),
    .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we), .memwb_we(memwb_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .memwb_flush(memwb_flush), .dmem_err(dmem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after negedge, compare against the model,
  // then advance the model to what the next posedge produces.
  task automatic cyc(input bit r, input bit imr, input bit mr, input bit mw,
                     input bit br, input bit dr, input bit exl, input int exrd,
                     input int rs1, input int rs2, input bit u1, input bit u2);
    bit lu, memop, busy;
    bit e_req, e_pc, e_sel, e_ifid, e_idex, e_exmem, e_memwb;
    bit f_ifid, f_idex, f_exmem, f_memwb;
    @(negedge clk);
    rst = r; imem_ready = imr; mem_mem_read = mr; mem_mem_write = mw;
    mem_branch_taken = br; dmem_ready = dr; ex_mem_read = exl;
    ex_register_rd = 5'(exrd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2;
    #1;
    lu    = exl && (exrd != 0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
    memop = mr || mw;
    busy  = (m_waiting || memop) && !dr;
    {e_req, e_pc, e_sel, e_ifid, e_idex, e_exmem, e_memwb} = '0;
    {f_ifid, f_idex, f_exmem, f_memwb} = '0;
    if (r) begin
      // everything low
    end else if (m_failed || busy) begin
      e_req   = !m_failed;
      e_memwb = 1; f_memwb = 1;
    end else begin
      e_req = m_waiting || memop;
      {e_pc, e_ifid, e_idex, e_exmem, e_memwb} = '1;
      if (br) begin
        e_sel = 1; f_ifid = 1; f_idex = 1; f_exmem = 1;
      end else if (lu) begin
        e_pc = 0; e_ifid = 0; f_idex = 1;
      end else if (!imr) begin
        e_pc = 0; f_ifid = 1;
      end
    end
    chk("ctrl{req,pc_we,sel,we[4],flush[4]}",
        {dmem_req, pc_we, pc_sel_branch, ifid_we, idex_we, exmem_we, memwb_we,
         ifid_flush, idex_flush, exmem_flush, memwb_flush},
        {e_req, e_pc, e_sel, e_ifid, e_idex, e_exmem, e_memwb,
         f_ifid, f_idex, f_exmem, f_memwb});
    chk("dmem_err", dmem_err, m_failed);
    chk("stall_cnt", stall_cnt, m_stalls);
    chk("flush_cnt", flush_cnt, m_flushes);
    if (r) begin
      m_waiting = 0; m_failed = 0; m_wait_cycles = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (!e_pc) m_stalls++;
      if (e_sel) m_flushes++;
      if (m_failed) begin
        // stuck until reset
      end else if (m_waiting) begin
        if (dr) begin
          m_waiting = 0;
        end else if (m_wait_cycles == TIMEOUT) begin
          m_waiting = 0; m_failed = 1;
        end else begin
          m_wait_cycles++;
        end
      end else if (memop && !dr) begin
        m_waiting = 1; m_wait_cycles = 0;
      end
    end
  endtask

  task automatic reset_cyc();
    cyc(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_cyc();
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int stuck;
    m_waiting = 0; m_failed = 0; m_wait_cycles = 0; m_stalls = 0; m_flushes = 0;
    rst = 1; imem_ready = 1; mem_mem_read = 0; mem_mem_write = 0;
    mem_branch_taken = 0; dmem_ready = 1; ex_mem_read = 0; ex_register_rd = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    @(posedge clk);

    // load-use on x5, then the same with rd=x0
    reset_cyc();
    cyc(0, 1, 0, 0, 0, 1, 1, 5, 5, 0, 1, 0);
    idle_cyc();
    chk("loaduse_stall", stall_cnt, 1);
    cyc(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1);
    idle_cyc();
    chk("x0_no_stall", stall_cnt, 1);

    // store with three wait cycles, released on the fourth
    reset_cyc();
    cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle_cyc();
    chk("store_wait_stall", stall_cnt, 3);

    // branch beats a coincident load-use
    reset_cyc();
    cyc(0, 1, 0, 0, 1, 1, 1, 7, 7, 7, 1, 1);
    idle_cyc();
    chk("branch_flush_cnt", flush_cnt, 1);
    chk("branch_no_stall", stall_cnt, 0);

    // two cycles of fetch wait
    reset_cyc();
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle_cyc();
    chk("fetch_wait_stall", stall_cnt, 2);

    // load that never completes: one RUN stall + five wait cycles -> ERR
    reset_cyc();
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_sticky", dmem_err, 1);
    chk("err_no_req", dmem_req, 0);
    chk("err_frozen_pc", pc_we, 0);
    cyc(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("err_ignores_ready", dmem_err, 1);
    reset_cyc();
    idle_cyc();
    chk("err_cleared", dmem_err, 0);
    chk("err_stall_cleared", stall_cnt, 0);

    // zero-wait load
    cyc(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("zero_wait_req", dmem_req, 1);
    chk("zero_wait_pc_we", pc_we, 1);
    idle_cyc();
    chk("zero_wait_no_stall", stall_cnt, 0);

    // randomized traffic
    stuck = 0;
    for (int n = 0; n < 3000; n++) begin
      bit dr;
      if (stuck == 0 && $urandom_range(39, 0) == 0) stuck = $urandom_range(9, 3);
      if (stuck > 0) begin
        dr = 0; stuck--;
      end else begin
        dr = ($urandom_range(2, 0) != 0);
      end
      cyc($urandom_range(79, 0) == 0,
          $urandom_range(3, 0) != 0,
          $urandom_range(5, 0) == 0,
          $urandom_range(5, 0) == 0,
          $urandom_range(4, 0) == 0,
          dr,
          $urandom_range(1, 0) == 0,
          $urandom_range(3, 0),
          $urandom_range(3, 0),
          $urandom_range(3, 0),
          $urandom_range(1, 0) == 0,
          $urandom_range(1, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_pipe_ctrl.md
Name: fb_pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage Firebird core. It drives the write-enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves four hazards: data-memory wait states, taken-branch redirect (resolved in MEM), load-use, and instruction-fetch wait. It owns the data-memory request handshake, a wait-state timeout and stall/flush performance counters.

Parameters:
DMEM_TIMEOUT, 255, max consecutive DMEM_WAIT cycles before error (8-bit counter compare)
CNT_W, 32, width of the stall/flush performance counters

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
imem_ready  in  1  instruction word valid this cycle
id_rs1  in  5  rs1 index of the instruction in ID
id_rs2  in  5  rs2 index of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_mem_read  in  1  instruction in EX is a load
ex_register_rd  in  5  rd of the instruction in EX
mem_mem_read  in  1  load in MEM
mem_mem_write  in  1  store in MEM
mem_branch_taken  in  1  branch/jump in MEM resolved taken
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data memory access request
pc_we  out  1  PC update enable
pc_sel_branch  out  1  PC selects branch target
ifid_we / idex_we / exmem_we / memwb_we  out  1 each  register write enables
ifid_flush / idex_flush / exmem_flush / memwb_flush  out  1 each  load bubble (all-zero) on next clk
dmem_err  out  1  sticky timeout error
stall_cnt  out  CNT_W  cycles with pc_we=0
flush_cnt  out  CNT_W  branch redirects taken

Behaviour:
- Clock port is clk; reset port is rst. One clock; reset is synchronous and active-high.
- Reset (rst=1 at posedge):
  - state=RUN, timeout counter=0, dmem_err=0, stall_cnt=0, flush_cnt=0.
  - While rst=1, all combinational outputs are forced to 0: every *_we, every *_flush, dmem_req and pc_sel_branch.
- Control outputs are combinational from state and inputs, so they act on the same posedge. State, counters and dmem_err are registered.
- Flush has priority over we inside each pipeline register. The controller never asserts we=0 together with flush=1 on the same register.
- States:
  - RUN
  - DMEM_WAIT
  - ERR
- Memory access (mem_mem_read | mem_mem_write) in RUN:
  - dmem_req=1.
  - If dmem_ready=1 in the same cycle, it is a zero-wait access and the pipeline advances normally.
  - If dmem_ready=0, go to DMEM_WAIT.
- DMEM_WAIT:
  - dmem_req=1.
  - pc_we, ifid_we, idex_we, exmem_we are 0.
  - memwb_flush=1, so no duplicate writeback occurs.
  - Timeout counter increments each cycle.
  - On dmem_ready=1: memwb_we=1, memwb_flush=0, and all other registers advance. Return to RUN and clear the counter.
  - On counter==DMEM_TIMEOUT with dmem_ready=0: go to ERR.
- ERR:
  - Pipeline frozen as in DMEM_WAIT, but dmem_req=0.
  - dmem_err=1.
  - Only rst exits.
- Priority in RUN, highest first:
  1. Memory wait (as above).
  2. Branch redirect (mem_branch_taken=1):
     - pc_we=1, pc_sel_branch=1.
     - ifid_flush, idex_flush, exmem_flush all =1.
     - memwb_we=1.
     - flush_cnt+1.
     - Load-use and imem_ready are ignored this cycle.
  3. Load-use: ex_mem_read & ex_register_rd!=0 & ((id_use_rs1 & id_rs1==ex_register_rd) | (id_use_rs2 & id_rs2==ex_register_rd)).
     - pc_we=0, ifid_we=0.
     - idex_flush=1.
     - exmem_we=1, memwb_we=1.
  4. Fetch wait (imem_ready=0):
     - pc_we=0.
     - ifid_flush=1.
     - Downstream stages advance.
  5. Otherwise all *_we=1, all flush=0.
- A simultaneous branch redirect and memory wait cannot occur, because a branch is not a memory op. If both are asserted anyway, the memory wait wins and the branch is re-evaluated on release.
- stall_cnt increments every cycle pc_we=0 (rst=0). Both counters wrap modulo 2^CNT_W.
- Reset asserted in DMEM_WAIT or ERR returns to RUN next cycle. dmem_req drops in the reset cycle.

Decomposition:
- fb_defines.v gains:
  - FB_PCTRL_RUN / FB_PCTRL_WAIT / FB_PCTRL_ERR 2-bit state encodings.
  - FB_PCTRL_TO_W (timeout counter width, 8).
- One combinational sub-module fb_hazard_detect implements the load-use comparison (inputs id_rs1/rs2, id_use_*, ex_mem_read, ex_register_rd; output load_use).

Test Plan:
- Load x5 in EX, ID uses rs1=5 -> one cycle with pc_we=0, ifid_we=0, idex_flush=1; stall_cnt 0->1. Same case with rd=0 -> no stall.
- Store in MEM with dmem_ready low for 3 cycles -> dmem_req high 4 cycles, 3 cycles of exmem_we=0 and memwb_flush=1, release on the 4th cycle; stall_cnt=3.
- mem_branch_taken=1 with a coincident load-use -> pc_sel_branch=1, ifid/idex/exmem_flush=1, no load-use stall; flush_cnt=1.
- imem_ready=0 for 2 cycles -> pc_we=0 and ifid_flush=1 for 2 cycles, idex/exmem/memwb_we=1.
- Load with dmem_ready never asserted (DMEM_TIMEOUT=4) -> ERR after 5 wait cycles, dmem_err=1, dmem_req=0, pipeline frozen; rst -> RUN, dmem_err=0, counters 0.
- Zero-wait load (dmem_ready=1 same cycle) -> dmem_req=1 one cycle, no stall, state stays RUN.
